program_loader: RTL and testbench
=================================

# program_loader

Boot-time controller for the instruction RAM behind `instruction_mem`. It accepts a byte stream over a valid/ready handshake and assembles little-endian halfwords. It sequences one write per halfword into consecutive RAM addresses while holding the CPU in reset, then releases the core and hands the RAM address port to the fetch stage.

## Interface
- `MAX_HALFWORDS`, default 512: largest accepted program length, in halfwords; matches the RAM depth.
- `clk_i  in  1`: sole clock; all state updates on the rising edge.
- `reset_n_i  in  1`: asynchronous, active-low reset.
- `start_i  in  1`: single-cycle request to begin a load.
- `byte_valid_i  in  1`: a stream byte is present.
- `byte_i  in  8`: stream byte.
- `byte_ready_o  out  1`: loader will accept a byte this cycle.
- `fetch_addr_i  in  WORD`: fetch-stage PC, used while running.
- `program_mem_write_en_o  out  1`: RAM write strobe.
- `instruction_o  out  HALF_WORD`: halfword to write.
- `instruction_addr_o  out  WORD`: RAM address, either the load address or `fetch_addr_i`.
- `cpu_reset_o  out  1`: active-high core reset; asserted in every state except RUN.
- `is_valid_o  out  1`: fetch-valid into the pipeline.
- `load_done_o  out  1`: the last load completed successfully.
- `load_error_o  out  1`: the last load aborted.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit halfword count N), then N pairs of (LO byte, HI byte). With `LOADER_CHECKSUM_EN` defined, a trailing CSUM byte follows.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CSUM, RUN, ERROR.
- IDLE, RUN or ERROR + `start_i` → LEN_LO. Clears the address counter, halfword counter, done, error and checksum.
- `start_i` is ignored in every other state.
- A byte is accepted when `byte_valid_i & byte_ready_o`.
- `byte_ready_o` = 1 only in LEN_LO, LEN_HI, DATA_LO, DATA_HI and CSUM.
- LEN_LO → LEN_HI on accept.
- LEN_HI on accept, with N = {`byte_i`, lo}:
  - N > `MAX_HALFWORDS` → ERROR.
  - N = 0 → CSUM if the macro is defined, else RUN.
  - Otherwise → DATA_LO.
- DATA_LO → DATA_HI on accept.
- DATA_HI → WRITE on accept. The registered halfword is {hi, lo}.
- WRITE lasts exactly one cycle:
  - `program_mem_write_en_o` = 1, `instruction_o` = halfword, `instruction_addr_o` = load address.
  - Load address then increments by 2; halfword count increments by 1.
  - → DATA_LO if count < N. Otherwise → CSUM (macro defined) or RUN.
- RUN: `instruction_addr_o` = `fetch_addr_i`, `cpu_reset_o` = 0, `load_done_o` = 1. The state holds until `start_i`.
- ERROR: `load_error_o` = 1 and `cpu_reset_o` = 1. The state holds until `start_i`.
- Addresses are byte addresses: 0, 2, …, 2(N−1). The load address counter is WORD wide and cannot wrap because N ≤ `MAX_HALFWORDS`.

## Timing
- Reset (asynchronous):
  - State = IDLE; `cpu_reset_o` = 1.
  - `byte_ready_o`, `program_mem_write_en_o`, `is_valid_o`, `load_done_o` and `load_error_o` = 0.
  - `instruction_o` = 0; load address = 0.
- Reset deasserted mid-load: the load is discarded and the state returns to IDLE. The RAM contents are undefined from the block's point of view.
- Write latency: the RAM write occurs in the cycle after the HI byte is accepted. Each halfword takes ≥3 cycles.
- `byte_ready_o` is a registered function of the state. It is 0 during WRITE, so back-to-back bytes stall for one cycle per halfword.
- `is_valid_o` rises one cycle after entering RUN, i.e. one cycle after `cpu_reset_o` falls.
- `is_valid_o` falls in the same cycle the state leaves RUN.
- `start_i` in RUN:
  - `cpu_reset_o` rises on the next edge.
  - The address mux switches to the load address on that same edge.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - A running XOR over all data bytes (not the length bytes) is kept.
  - In CSUM, the accepted byte is compared with the XOR: equal → RUN, else → ERROR.
- `LOADER_CHECKSUM_EN` undefined: the CSUM state and the accumulator are absent. The last WRITE, or N = 0, goes directly to RUN.

## Structure
- A shared package holds:
  - the `loader_state_e` enum;
  - the `LOADER_BYTE` width constant (8);
  - the existing WORD and HALF_WORD widths.
- One sub-module, `loader_xor_acc`: an 8-bit accumulator with clear and enable, instantiated only under `LOADER_CHECKSUM_EN`.

## Test plan
- Reset, then stream 02 00 34 12 78 56 with the macro off → writes of 0x1234 @0 and 0x5678 @2. Then RUN, `cpu_reset_o` = 0, and `is_valid_o` = 1 one cycle later.
- Stream length 0x0201 (513 > 512) → ERROR, `load_error_o` = 1, no write strobes, `cpu_reset_o` stays 1.
- Macro on: stream 01 00 34 12 26 → RUN (0x34 ^ 0x12 = 0x26). The same stream with 27 → ERROR.
- Hold `byte_valid_i` high continuously → `byte_ready_o` = 0 during every WRITE cycle; no byte lost or duplicated.
- `start_i` pulsed in DATA_HI → ignored. `start_i` in RUN → `cpu_reset_o` = 1 next cycle, `is_valid_o` = 0 in that same cycle, and the address mux returns to the load counter at 0.
- Assert `reset_n_i` low mid-DATA_LO → all outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/program_loader_pkg.sv
// ============================================================================
// Module      : program_loader_pkg
// Description : Shared widths and FSM state encoding for the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package program_loader_pkg;

  localparam int WORD        = 32;
  localparam int HALF_WORD   = 16;
  localparam int LOADER_BYTE = 8;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_LO  = 4'd1,
    S_LEN_HI  = 4'd2,
    S_DATA_LO = 4'd3,
    S_DATA_HI = 4'd4,
    S_WRITE   = 4'd5,
    S_CSUM    = 4'd6,
    S_RUN     = 4'd7,
    S_ERROR   = 4'd8
  } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/loader_xor_acc.sv
// ============================================================================
// Module      : loader_xor_acc
// Description : 8-bit running XOR accumulator with synchronous clear and enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module loader_xor_acc
  import program_loader_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic [LOADER_BYTE-1:0] data_i,
  output logic [LOADER_BYTE-1:0] acc_o
);

  logic [LOADER_BYTE-1:0] r_acc;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_acc <= '0;
    end else if (clr_i) begin
      r_acc <= '0;
    end else if (en_i) begin
      r_acc <= r_acc ^ data_i;
    end
  end

  assign acc_o = r_acc;

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module      : program_loader
// Description : Boot-time byte-stream loader for the instruction RAM; holds the
//               core in reset until the program is written. Optional trailing
//               XOR checksum enabled by macro LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader
  import program_loader_pkg::*;
#(
  parameter int MAX_HALFWORDS = 512
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   start_i,
  input  logic                   byte_valid_i,
  input  logic [LOADER_BYTE-1:0] byte_i,
  output logic                   byte_ready_o,
  input  logic [WORD-1:0]        fetch_addr_i,
  output logic                   program_mem_write_en_o,
  output logic [HALF_WORD-1:0]   instruction_o,
  output logic [WORD-1:0]        instruction_addr_o,
  output logic                   cpu_reset_o,
  output logic                   is_valid_o,
  output logic                   load_done_o,
  output logic                   load_error_o
);

  localparam logic [HALF_WORD-1:0] c_max_hw = HALF_WORD'(MAX_HALFWORDS);

  loader_state_e          r_state;
  loader_state_e          w_next;
  logic                   w_ready_next;
  logic                   r_byte_ready;
  logic                   r_is_valid;
  logic [LOADER_BYTE-1:0] r_lo;
  logic [HALF_WORD-1:0]   r_len;
  logic [HALF_WORD-1:0]   r_count;
  logic [HALF_WORD-1:0]   r_half;
  logic [WORD-1:0]        r_load_addr;
  logic                   w_accept;
  logic                   w_start;
  logic [HALF_WORD-1:0]   w_len;

  assign w_accept = byte_valid_i & r_byte_ready;
  assign w_start  = start_i & (r_state inside {S_IDLE, S_RUN, S_ERROR});
  assign w_len    = {byte_i, r_lo};

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e c_after_data = S_CSUM;
  logic [LOADER_BYTE-1:0] w_xor;

  loader_xor_acc u_xor_acc (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (w_start),
    .en_i      (w_accept & (r_state inside {S_DATA_LO, S_DATA_HI})),
    .data_i    (byte_i),
    .acc_o     (w_xor)
  );
`else
  localparam loader_state_e c_after_data = S_RUN;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_ready_next = 1'b0;
    case (r_state)
      S_IDLE, S_RUN, S_ERROR: if (start_i) w_next = S_LEN_LO;
      S_LEN_LO:  if (w_accept) w_next = S_LEN_HI;
      S_LEN_HI: begin
        if (w_accept) begin
          if (w_len > c_max_hw)   w_next = S_ERROR;
          else if (w_len == '0)   w_next = c_after_data;
          else                    w_next = S_DATA_LO;
        end
      end
      S_DATA_LO: if (w_accept) w_next = S_DATA_HI;
      S_DATA_HI: if (w_accept) w_next = S_WRITE;
      // Count has not yet been bumped for this write, hence the +1.
      S_WRITE:   w_next = (r_count + 16'd1 < r_len) ? S_DATA_LO : c_after_data;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:    if (w_accept) w_next = (byte_i == w_xor) ? S_RUN : S_ERROR;
`endif
      default:   w_next = S_IDLE;
    endcase
    w_ready_next = w_next inside {S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CSUM};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_byte_ready <= 1'b0;
      r_is_valid   <= 1'b0;
      r_lo         <= '0;
      r_len        <= '0;
      r_count      <= '0;
      r_half       <= '0;
      r_load_addr  <= '0;
    end else begin
      r_byte_ready <= w_ready_next;
      // Valid trails RUN entry by one cycle but drops with the exit edge.
      r_is_valid   <= (r_state == S_RUN) && (w_next == S_RUN);
      if (w_start) begin
        r_load_addr <= '0;
        r_count     <= '0;
      end else if (r_state == S_WRITE) begin
        r_load_addr <= r_load_addr + WORD'(2);
        r_count     <= r_count + 16'd1;
      end
      if (w_accept && (r_state inside {S_LEN_LO, S_DATA_LO})) r_lo <= byte_i;
      if (w_accept && (r_state == S_LEN_HI))  r_len  <= w_len;
      if (w_accept && (r_state == S_DATA_HI)) r_half <= {byte_i, r_lo};
    end
  end

  assign byte_ready_o           = r_byte_ready;
  assign program_mem_write_en_o = (r_state == S_WRITE);
  assign instruction_o          = r_half;
  assign instruction_addr_o     = (r_state == S_RUN) ? fetch_addr_i : r_load_addr;
  assign cpu_reset_o            = (r_state != S_RUN);
  assign is_valid_o             = r_is_valid;
  assign load_done_o            = (r_state == S_RUN);
  assign load_error_o           = (r_state == S_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader: directed table, random
//               streams against a stream-level model, and corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic [31:0] fetch_addr_i;
  logic        program_mem_write_en_o;
  logic [15:0] instruction_o;
  logic [31:0] instruction_addr_o;
  logic        cpu_reset_o;
  logic        is_valid_o;
  logic        load_done_o;
  logic        load_error_o;

  always #5 clk = ~clk;

  program_loader #(.MAX_HALFWORDS(512)) dut (
    .clk_i                  (clk),
    .reset_n_i              (reset_n_i),
    .start_i                (start_i),
    .byte_valid_i           (byte_valid_i),
    .byte_i                 (byte_i),
    .byte_ready_o           (byte_ready_o),
    .fetch_addr_i           (fetch_addr_i),
    .program_mem_write_en_o (program_mem_write_en_o),
    .instruction_o          (instruction_o),
    .instruction_addr_o     (instruction_addr_o),
    .cpu_reset_o            (cpu_reset_o),
    .is_valid_o             (is_valid_o),
    .load_done_o            (load_done_o),
    .load_error_o           (load_error_o)
  );

  typedef struct {
    string       name;
    int          nb;
    logic [7:0]  b[8];
    bit          err;
    int          nw;
    logic [15:0] w[3];
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [47:0] cap_q[$];
  logic [47:0] exp_q[$];
  bit          exp_err;
  logic [7:0]  sq[$];
  vec_t        vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n_i && program_mem_write_en_o) begin
      cap_q.push_back({instruction_addr_o, instruction_o});
      check("ready_in_write", 32'(byte_ready_o), 32'd0);
    end
  end

  // Expected writes and outcome derived directly from the stream format.
  task automatic model();
    int n;
    exp_q.delete();
    n = int'({sq[1], sq[0]});
    exp_err = (n > 512);
    if (!exp_err) begin
      for (int i = 0; i < n; i++)
        exp_q.push_back({32'(2 * i), sq[3 + 2 * i], sq[2 + 2 * i]});
`ifdef LOADER_CHECKSUM_EN
      begin
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 2 * n; i++) x ^= sq[2 + i];
        exp_err = (sq[2 + 2 * n] != x);
      end
`endif
    end
  endtask

  task automatic make_stream(input int n, input bit bad);
    logic [7:0] x;
    logic [7:0] d;
    sq.delete();
    x = 8'h00;
    sq.push_back(n[7:0]);
    sq.push_back(n[15:8]);
    if (n <= 512) begin
      for (int i = 0; i < 2 * n; i++) begin
        d = 8'($urandom);
        x ^= d;
        sq.push_back(d);
      end
`ifdef LOADER_CHECKSUM_EN
      sq.push_back(bad ? (x ^ 8'h5A) : x);
`else
      if (bad) x = 8'h00;
`endif
    end
  endtask

  task automatic begin_load();
    @(negedge clk);
    start_i      = 1'b1;
    byte_valid_i = 1'b0;
    cap_q.delete();
    fetch_addr_i = $urandom;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send(input bit gaps, input int start_at);
    int idx = 0;
    int cyc = 0;
    int lim = 20 * sq.size() + 100;
    bit pulsed = 1'b0;
    while (idx < sq.size() && cyc < lim) begin
      if (idx == start_at && !pulsed) begin
        start_i      = 1'b1;
        byte_valid_i = 1'b0;
        pulsed       = 1'b1;
      end else begin
        start_i      = 1'b0;
        byte_valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        byte_i       = sq[idx];
        if (byte_valid_i && byte_ready_o) idx++;
      end
      @(negedge clk);
      cyc++;
    end
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    check("stream_consumed", 32'(idx), 32'(sq.size()));
  endtask

  task automatic finish_check(input string name);
    int k = 0;
    while (!(load_done_o || load_error_o) && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({name, ":error"},     32'(load_error_o), 32'(exp_err));
    check({name, ":done"},      32'(load_done_o),  32'(!exp_err));
    check({name, ":cpu_reset"}, 32'(cpu_reset_o),  32'(exp_err));
    check({name, ":nwrites"},   32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      check({name, ":waddr"}, cap_q[i][47:16], exp_q[i][47:16]);
      check({name, ":wdata"}, 32'(cap_q[i][15:0]), 32'(exp_q[i][15:0]));
    end
    if (!exp_err) begin
      check({name, ":valid_first"}, 32'(is_valid_o), 32'd0);
      check({name, ":fetch_mux"},   instruction_addr_o, fetch_addr_i);
      @(negedge clk);
      check({name, ":valid_next"},  32'(is_valid_o), 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i    = 1'b0;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_i       = 8'h00;
    fetch_addr_i = 32'h0;

`ifdef LOADER_CHECKSUM_EN
    vt.push_back('{"two_hw", 7, '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h08, 8'h00}, 1'b0, 2, '{16'h1234, 16'h5678, 16'h0}});
    vt.push_back('{"len0",   3, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 0, '{16'h0, 16'h0, 16'h0}});
    vt.push_back('{"csum_bad", 5, '{8'h01, 8'h00, 8'h34, 8'h12, 8'h27, 8'h00, 8'h00, 8'h00}, 1'b1, 1, '{16'h1234, 16'h0, 16'h0}});
    vt.push_back('{"csum_ok",  5, '{8'h01, 8'h00, 8'h34, 8'h12, 8'h26, 8'h00, 8'h00, 8'h00}, 1'b0, 1, '{16'h1234, 16'h0, 16'h0}});
`else
    vt.push_back('{"two_hw", 6, '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h00, 8'h00}, 1'b0, 2, '{16'h1234, 16'h5678, 16'h0}});
    vt.push_back('{"len0",   2, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 0, '{16'h0, 16'h0, 16'h0}});
    vt.push_back('{"one_hw", 4, '{8'h01, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1, '{16'h00FF, 16'h0, 16'h0}});
`endif
    vt.push_back('{"len513", 2, '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 0, '{16'h0, 16'h0, 16'h0}});

    repeat (3) @(negedge clk);
    check("rst:cpu_reset", 32'(cpu_reset_o), 32'd1);
    check("rst:ready",     32'(byte_ready_o), 32'd0);
    check("rst:we",        32'(program_mem_write_en_o), 32'd0);
    check("rst:valid",     32'(is_valid_o), 32'd0);
    check("rst:done",      32'(load_done_o), 32'd0);
    check("rst:error",     32'(load_error_o), 32'd0);
    check("rst:instr",     32'(instruction_o), 32'd0);
    check("rst:addr",      instruction_addr_o, 32'd0);
    reset_n_i = 1'b1;
    @(negedge clk);
    check("idle:cpu_reset", 32'(cpu_reset_o), 32'd1);
    check("idle:ready",     32'(byte_ready_o), 32'd0);

    // Directed table with hand-computed expectations.
    foreach (vt[v]) begin
      sq.delete();
      for (int i = 0; i < vt[v].nb; i++) sq.push_back(vt[v].b[i]);
      exp_q.delete();
      for (int i = 0; i < vt[v].nw; i++) exp_q.push_back({32'(2 * i), vt[v].w[i]});
      exp_err = vt[v].err;
      begin_load();
      send(1'b0, -1);
      finish_check(vt[v].name);
    end

    // Successful load, then start while running.
    make_stream(3, 1'b0);
    model();
    begin_load();
    send(1'b0, -1);
    finish_check("pre_restart");
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("restart:cpu_reset", 32'(cpu_reset_o), 32'd1);
    check("restart:valid",     32'(is_valid_o), 32'd0);
    check("restart:addr",      instruction_addr_o, 32'd0);
    check("restart:done",      32'(load_done_o), 32'd0);
    check("restart:ready",     32'(byte_ready_o), 32'd1);

    // Start pulsed while in DATA_HI must be ignored.
    sq.delete();
    sq.push_back(8'h01); sq.push_back(8'h00); sq.push_back(8'hAA); sq.push_back(8'hBB);
`ifdef LOADER_CHECKSUM_EN
    sq.push_back(8'h11);
`endif
    model();
    cap_q.delete();
    send(1'b0, 3);
    finish_check("start_in_data_hi");

    // Random streams, including both length boundaries.
    for (int r = 0; r < 14; r++) begin
      int n;
      n = (r == 12) ? 512 : (r == 13) ? 513 : int'($urandom_range(0, 20));
      make_stream(n, $urandom_range(0, 3) == 0);
      model();
      begin_load();
      send(r[0], -1);
      finish_check($sformatf("rand%0d_n%0d", r, n));
    end

    // Asynchronous reset while in DATA_LO after one write.
    sq.delete();
    sq.push_back(8'h02); sq.push_back(8'h00); sq.push_back(8'h11); sq.push_back(8'h22);
    begin_load();
    send(1'b0, -1);
    @(negedge clk);
    check("mid:addr",  instruction_addr_o, 32'd2);
    check("mid:instr", 32'(instruction_o), 32'h2211);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("async:ready",     32'(byte_ready_o), 32'd0);
    check("async:cpu_reset", 32'(cpu_reset_o), 32'd1);
    check("async:we",        32'(program_mem_write_en_o), 32'd0);
    check("async:valid",     32'(is_valid_o), 32'd0);
    check("async:done",      32'(load_done_o), 32'd0);
    check("async:error",     32'(load_error_o), 32'd0);
    check("async:instr",     32'(instruction_o), 32'd0);
    check("async:addr",      instruction_addr_o, 32'd0);
    @(negedge clk);
    reset_n_i = 1'b1;
    @(negedge clk);
    check("post_rst:ready", 32'(byte_ready_o), 32'd0);
    check("post_rst:cpu_reset", 32'(cpu_reset_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
